// File: rtl/dataflow_perf_pkg.sv
// Shared types and read-select encodings for the dataflow performance monitor.
package dataflow_perf_pkg;

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StRun      = 2'd1,
    StDoneWait = 2'd2
  } chan_state_e;

  localparam logic [2:0] SelTxn     = 3'd0;
  localparam logic [2:0] SelBusy    = 3'd1;
  localparam logic [2:0] SelStall   = 3'd2;
  localparam logic [2:0] SelIter    = 3'd3;
  localparam logic [2:0] SelLastLat = 3'd4;
  localparam logic [2:0] SelMaxLat  = 3'd5;
  localparam logic [2:0] SelStatus  = 3'd6;
  localparam logic [2:0] SelZero    = 3'd7;

endpackage

// File: rtl/dataflow_perf_chan.sv
// One monitored ap_ctrl channel: handshake FSM plus saturating performance counters.
module dataflow_perf_chan
  import dataflow_perf_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             freeze,
  input  logic             ap_start,
  input  logic             ap_done,
  input  logic             ap_continue,
  input  logic             iter_start_en,
  input  logic             iter_start_blk,
  input  logic             iter_end_en,
  input  logic             iter_end_blk,
  output chan_state_e      state,
  output logic             ovf,
  output logic [CNT_W-1:0] txn,
  output logic [CNT_W-1:0] busy_cyc,
  output logic [CNT_W-1:0] stall_cyc,
  output logic [CNT_W-1:0] iter,
  output logic [CNT_W-1:0] last_lat,
  output logic [CNT_W-1:0] max_lat
);

  localparam logic [CNT_W-1:0] CntMax = '1;

  chan_state_e      state_q;
  logic             ovf_q;
  logic [CNT_W-1:0] txn_q, busy_q, stall_q, iter_q, last_q, max_q, lat_q;

  logic             run_cyc, lat_cyc, done_cyc, stall_ev, iter_ev, sat_hit;
  logic [CNT_W-1:0] cur_lat;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CntMax) ? v : v + CNT_W'(1);
  endfunction

  // The start cycle in IDLE already counts as the first RUN cycle of a transaction.
  always_comb begin
    run_cyc  = (state_q == StRun) || ((state_q == StIdle) && ap_start);
    lat_cyc  = run_cyc || (state_q == StDoneWait);
    done_cyc = ap_continue && ((state_q == StDoneWait) || (ap_done && run_cyc));
    stall_ev = run_cyc && iter_start_en && iter_start_blk;
    iter_ev  = iter_end_en && !iter_end_blk;
    cur_lat  = sat_inc(lat_q);
    sat_hit  = (run_cyc && (busy_q == CntMax)) || (stall_ev && (stall_q == CntMax)) ||
               (iter_ev && (iter_q == CntMax)) || (done_cyc && (txn_q == CntMax)) ||
               (lat_cyc && (lat_q == CntMax));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
      ovf_q   <= 1'b0;
      txn_q   <= '0;
      busy_q  <= '0;
      stall_q <= '0;
      iter_q  <= '0;
      last_q  <= '0;
      max_q   <= '0;
      lat_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (ap_start) begin
            if (ap_done && ap_continue) state_q <= StIdle;
            else if (ap_done)           state_q <= StDoneWait;
            else                        state_q <= StRun;
          end
        end
        StRun: begin
          if (ap_done) begin
            if (ap_continue) state_q <= ap_start ? StRun : StIdle;
            else             state_q <= StDoneWait;
          end
        end
        StDoneWait: begin
          if (ap_continue) state_q <= ap_start ? StRun : StIdle;
        end
        default: state_q <= StIdle;
      endcase

      // Clear takes priority and drops any event seen in the same cycle.
      if (clear) begin
        ovf_q   <= 1'b0;
        txn_q   <= '0;
        busy_q  <= '0;
        stall_q <= '0;
        iter_q  <= '0;
        last_q  <= '0;
        max_q   <= '0;
        lat_q   <= '0;
      end else if (!freeze) begin
        if (run_cyc)  busy_q  <= sat_inc(busy_q);
        if (stall_ev) stall_q <= sat_inc(stall_q);
        if (iter_ev)  iter_q  <= sat_inc(iter_q);
        if (lat_cyc)  lat_q   <= done_cyc ? '0 : cur_lat;
        if (done_cyc) begin
          txn_q  <= sat_inc(txn_q);
          last_q <= cur_lat;
          if (cur_lat > max_q) max_q <= cur_lat;
        end
        if (sat_hit) ovf_q <= 1'b1;
      end
    end
  end

  assign state     = state_q;
  assign ovf       = ovf_q;
  assign txn       = txn_q;
  assign busy_cyc  = busy_q;
  assign stall_cyc = stall_q;
  assign iter      = iter_q;
  assign last_lat  = last_q;
  assign max_lat   = max_q;

endmodule

// File: rtl/dataflow_perf_monitor.sv
// Multi-channel ap_ctrl performance monitor: per-channel trackers, finish freeze, read port.
module dataflow_perf_monitor
  import dataflow_perf_pkg::*;
#(
  parameter int unsigned N_CH  = 4,
  parameter int unsigned CNT_W = 32,
  localparam int unsigned CH_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             finish,
  input  logic             clear,
  input  logic [N_CH-1:0]  ap_start,
  input  logic [N_CH-1:0]  ap_ready,
  input  logic [N_CH-1:0]  ap_done,
  input  logic [N_CH-1:0]  ap_continue,
  input  logic [N_CH-1:0]  iter_start_en,
  input  logic [N_CH-1:0]  iter_start_blk,
  input  logic [N_CH-1:0]  iter_end_en,
  input  logic [N_CH-1:0]  iter_end_blk,
  input  logic             rd_req,
  input  logic [CH_W-1:0]  rd_ch,
  input  logic [2:0]       rd_sel,
  output logic             rd_valid,
  output logic [CNT_W-1:0] rd_data,
  output logic [N_CH-1:0]  busy,
  output logic [N_CH-1:0]  ovf
);

  chan_state_e      st_c     [N_CH];
  logic [CNT_W-1:0] txn_c    [N_CH];
  logic [CNT_W-1:0] busy_c   [N_CH];
  logic [CNT_W-1:0] stall_c  [N_CH];
  logic [CNT_W-1:0] iter_c   [N_CH];
  logic [CNT_W-1:0] last_c   [N_CH];
  logic [CNT_W-1:0] max_c    [N_CH];
  logic [N_CH-1:0]  ovf_c;

  logic             frozen_q, rd_valid_q;
  logic [CNT_W-1:0] rd_data_q, rd_mux;

  // ap_ready is observed only for interface completeness; no counter depends on it.
  logic unused_ap_ready;
  assign unused_ap_ready = ^ap_ready;

  for (genvar g = 0; g < N_CH; g++) begin : g_chan
    dataflow_perf_chan #(
      .CNT_W(CNT_W)
    ) u_chan (
      .clock          (clock),
      .reset          (reset),
      .clear          (clear),
      .freeze         (frozen_q),
      .ap_start       (ap_start[g]),
      .ap_done        (ap_done[g]),
      .ap_continue    (ap_continue[g]),
      .iter_start_en  (iter_start_en[g]),
      .iter_start_blk (iter_start_blk[g]),
      .iter_end_en    (iter_end_en[g]),
      .iter_end_blk   (iter_end_blk[g]),
      .state          (st_c[g]),
      .ovf            (ovf_c[g]),
      .txn            (txn_c[g]),
      .busy_cyc       (busy_c[g]),
      .stall_cyc      (stall_c[g]),
      .iter           (iter_c[g]),
      .last_lat       (last_c[g]),
      .max_lat        (max_c[g])
    );
    assign busy[g] = (st_c[g] != StIdle);
  end

  assign ovf = ovf_c;

  // Out-of-range channels match no loop iteration and read back as zero.
  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (rd_ch == CH_W'(i)) begin
        case (rd_sel)
          SelTxn:     rd_mux = txn_c[i];
          SelBusy:    rd_mux = busy_c[i];
          SelStall:   rd_mux = stall_c[i];
          SelIter:    rd_mux = iter_c[i];
          SelLastLat: rd_mux = last_c[i];
          SelMaxLat:  rd_mux = max_c[i];
          SelStatus:  rd_mux = {{(CNT_W-3){1'b0}}, ovf_c[i], st_c[i]};
          default:    rd_mux = '0;
        endcase
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      frozen_q   <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      if (finish) frozen_q <= 1'b1;
      rd_valid_q <= rd_req;
      if (rd_req) rd_data_q <= rd_mux;
    end
  end

  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;

endmodule

// File: tb/tb_dataflow_perf_monitor.sv
// Scenario bench for dataflow_perf_monitor: reads are queued with expectations and compared.
module tb_dataflow_perf_monitor;

  localparam int N_CH  = 3;
  localparam int CNT_W = 8;
  localparam int CH_W  = 2;

  logic             clock = 1'b0;
  logic             reset, finish, clear;
  logic [N_CH-1:0]  ap_start, ap_ready, ap_done, ap_continue;
  logic [N_CH-1:0]  iter_start_en, iter_start_blk, iter_end_en, iter_end_blk;
  logic             rd_req;
  logic [CH_W-1:0]  rd_ch;
  logic [2:0]       rd_sel;
  logic             rd_valid;
  logic [CNT_W-1:0] rd_data;
  logic [N_CH-1:0]  busy, ovf;

  int n_cmp = 0;
  int n_bad = 0;

  logic [CNT_W-1:0] exp_q[$];
  logic [CNT_W-1:0] got_q[$];
  logic             vld_q[$];
  string            name_q[$];

  dataflow_perf_monitor #(
    .N_CH  (N_CH),
    .CNT_W (CNT_W)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .finish         (finish),
    .clear          (clear),
    .ap_start       (ap_start),
    .ap_ready       (ap_ready),
    .ap_done        (ap_done),
    .ap_continue    (ap_continue),
    .iter_start_en  (iter_start_en),
    .iter_start_blk (iter_start_blk),
    .iter_end_en    (iter_end_en),
    .iter_end_blk   (iter_end_blk),
    .rd_req         (rd_req),
    .rd_ch          (rd_ch),
    .rd_sel         (rd_sel),
    .rd_valid       (rd_valid),
    .rd_data        (rd_data),
    .busy           (busy),
    .ovf            (ovf)
  );

  always #5 clock = ~clock;

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    finish = 1'b0; clear = 1'b0;
    ap_start = '0; ap_ready = '0; ap_done = '0; ap_continue = '1;
    iter_start_en = '0; iter_start_blk = '0; iter_end_en = '0; iter_end_blk = '0;
    rd_req = 1'b0; rd_ch = '0; rd_sel = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
  endtask

  // Issue one read, queue its expectation, and capture what the DUT returns a cycle later.
  task automatic rd(input int ch, input int sel, input logic [CNT_W-1:0] exp, input string nm);
    rd_req = 1'b1; rd_ch = CH_W'(ch); rd_sel = 3'(sel);
    exp_q.push_back(exp); name_q.push_back(nm);
    tick(1);
    got_q.push_back(rd_data); vld_q.push_back(rd_valid);
    rd_req = 1'b0;
  endtask

  task automatic test_reset();
    logic [CNT_W-1:0] e, g; logic v; string nm;
    do_reset();
    n_cmp++; if (rd_valid !== 1'b0) begin n_bad++; $display("FAIL reset rd_valid: got %b want 0", rd_valid); end
    n_cmp++; if (rd_data !== '0) begin n_bad++; $display("FAIL reset rd_data: got %0d want 0", rd_data); end
    n_cmp++; if (busy !== '0) begin n_bad++; $display("FAIL reset busy: got %b want 0", busy); end
    n_cmp++; if (ovf !== '0) begin n_bad++; $display("FAIL reset ovf: got %b want 0", ovf); end
    for (int s = 0; s < 8; s++) rd(0, s, '0, $sformatf("reset ch0 sel%0d", s));
    while (exp_q.size() > 0) begin
      n_cmp++; e = exp_q.pop_front(); g = got_q.pop_front(); v = vld_q.pop_front(); nm = name_q.pop_front();
      if (v !== 1'b1 || g !== e) begin n_bad++; $display("FAIL %s: got valid=%b data=%0d want valid=1 data=%0d", nm, v, g, e); end
    end
  endtask

  task automatic test_txn_ch0();
    logic [CNT_W-1:0] e, g; logic v; string nm;
    tick(3);
    ap_start[0] = 1'b1; iter_start_en[0] = 1'b1; iter_start_blk[0] = 1'b1; iter_end_en[0] = 1'b1;
    tick();
    n_cmp++; if (busy[0] !== 1'b1) begin n_bad++; $display("FAIL ch0 busy in run: got %b want 1", busy[0]); end
    ap_start[0] = 1'b0;
    tick();
    iter_start_en[0] = 1'b0; iter_start_blk[0] = 1'b0;
    tick();
    iter_end_blk[0] = 1'b1;
    tick();
    iter_end_en[0] = 1'b0; iter_end_blk[0] = 1'b0; ap_done[0] = 1'b1;
    tick();
    ap_done[0] = 1'b0;
    n_cmp++; if (busy[0] !== 1'b0) begin n_bad++; $display("FAIL ch0 busy after done: got %b want 0", busy[0]); end
    rd(0, 0, 8'd1, "ch0 txn");
    rd(0, 1, 8'd5, "ch0 busy_cyc");
    rd(0, 2, 8'd2, "ch0 stall_cyc");
    rd(0, 3, 8'd3, "ch0 iter");
    rd(0, 4, 8'd5, "ch0 last_lat");
    rd(0, 5, 8'd5, "ch0 max_lat");
    rd(0, 6, 8'd0, "ch0 status");
    rd(1, 1, 8'd0, "ch1 busy_cyc untouched");
    while (exp_q.size() > 0) begin
      n_cmp++; e = exp_q.pop_front(); g = got_q.pop_front(); v = vld_q.pop_front(); nm = name_q.pop_front();
      if (v !== 1'b1 || g !== e) begin n_bad++; $display("FAIL %s: got valid=%b data=%0d want valid=1 data=%0d", nm, v, g, e); end
    end
  endtask

  task automatic test_done_wait();
    logic [CNT_W-1:0] e, g; logic v; string nm;
    ap_continue[1] = 1'b0; ap_start[1] = 1'b1;
    tick();
    ap_start[1] = 1'b0; ap_done[1] = 1'b1;
    tick();
    rd(1, 6, 8'd2, "ch1 status in done_wait");
    rd(1, 0, 8'd0, "ch1 txn in done_wait");
    n_cmp++; if (busy[1] !== 1'b1) begin n_bad++; $display("FAIL ch1 busy in done_wait: got %b want 1", busy[1]); end
    ap_done[1] = 1'b0; ap_continue[1] = 1'b1;
    tick();
    rd(1, 0, 8'd1, "ch1 txn after continue");
    rd(1, 1, 8'd2, "ch1 busy_cyc");
    rd(1, 4, 8'd5, "ch1 last_lat incl wait");
    rd(1, 6, 8'd0, "ch1 status idle");
    while (exp_q.size() > 0) begin
      n_cmp++; e = exp_q.pop_front(); g = got_q.pop_front(); v = vld_q.pop_front(); nm = name_q.pop_front();
      if (v !== 1'b1 || g !== e) begin n_bad++; $display("FAIL %s: got valid=%b data=%0d want valid=1 data=%0d", nm, v, g, e); end
    end
  endtask

  task automatic test_back_to_back();
    logic [CNT_W-1:0] e, g; logic v; string nm;
    ap_start[2] = 1'b1;
    tick();
    ap_start[2] = 1'b0;
    tick();
    ap_start[2] = 1'b1; ap_done[2] = 1'b1;
    tick();
    n_cmp++; if (busy[2] !== 1'b1) begin n_bad++; $display("FAIL ch2 busy between txns: got %b want 1", busy[2]); end
    ap_start[2] = 1'b0; ap_done[2] = 1'b0;
    tick(6);
    ap_done[2] = 1'b1;
    tick();
    ap_done[2] = 1'b0;
    rd(2, 0, 8'd2, "ch2 txn b2b");
    rd(2, 4, 8'd7, "ch2 last_lat b2b");
    rd(2, 5, 8'd7, "ch2 max_lat b2b");
    ap_start[2] = 1'b1;
    tick();
    ap_start[2] = 1'b0; ap_done[2] = 1'b1;
    tick();
    ap_done[2] = 1'b0;
    rd(2, 0, 8'd3, "ch2 txn third");
    rd(2, 4, 8'd2, "ch2 last_lat third");
    rd(2, 5, 8'd7, "ch2 max_lat kept");
    rd(2, 1, 8'd12, "ch2 busy_cyc");
    while (exp_q.size() > 0) begin
      n_cmp++; e = exp_q.pop_front(); g = got_q.pop_front(); v = vld_q.pop_front(); nm = name_q.pop_front();
      if (v !== 1'b1 || g !== e) begin n_bad++; $display("FAIL %s: got valid=%b data=%0d want valid=1 data=%0d", nm, v, g, e); end
    end
  endtask

  task automatic test_saturation();
    logic [CNT_W-1:0] e, g; logic v; string nm;
    do_reset();
    ap_start[0] = 1'b1;
    tick();
    ap_start[0] = 1'b0;
    tick(299);
    rd(0, 1, 8'd255, "sat busy_cyc");
    n_cmp++; if (ovf[0] !== 1'b1) begin n_bad++; $display("FAIL sat ovf: got %b want 1", ovf[0]); end
    rd(0, 6, 8'd5, "sat status");
    clear = 1'b1;
    tick();
    clear = 1'b0;
    n_cmp++; if (ovf[0] !== 1'b0) begin n_bad++; $display("FAIL clear ovf: got %b want 0", ovf[0]); end
    rd(0, 1, 8'd0, "clear busy_cyc");
    rd(0, 6, 8'd1, "clear keeps state");
    ap_done[0] = 1'b1;
    tick();
    ap_done[0] = 1'b0;
    while (exp_q.size() > 0) begin
      n_cmp++; e = exp_q.pop_front(); g = got_q.pop_front(); v = vld_q.pop_front(); nm = name_q.pop_front();
      if (v !== 1'b1 || g !== e) begin n_bad++; $display("FAIL %s: got valid=%b data=%0d want valid=1 data=%0d", nm, v, g, e); end
    end
  endtask

  task automatic test_finish();
    logic [CNT_W-1:0] e, g; logic v; string nm;
    do_reset();
    ap_start[0] = 1'b1;
    tick();
    ap_start[0] = 1'b0; ap_done[0] = 1'b1;
    tick();
    ap_done[0] = 1'b0;
    finish = 1'b1;
    tick();
    finish = 1'b0;
    ap_start = 3'b011; ap_done[1] = 1'b1; iter_end_en[2] = 1'b1;
    tick();
    ap_start = '0; ap_done = '0; iter_end_en = '0;
    tick();
    ap_done[0] = 1'b1;
    tick();
    ap_done[0] = 1'b0; ap_start[0] = 1'b1;
    tick();
    ap_start[0] = 1'b0;
    rd(0, 0, 8'd1, "frozen ch0 txn");
    rd(0, 1, 8'd2, "frozen ch0 busy_cyc");
    rd(0, 4, 8'd2, "frozen ch0 last_lat");
    rd(1, 0, 8'd0, "frozen ch1 txn");
    rd(2, 3, 8'd0, "frozen ch2 iter");
    rd(0, 6, 8'd1, "frozen fsm tracks");
    rd(N_CH, 6, 8'd0, "out of range ch status");
    rd(N_CH, 0, 8'd0, "out of range ch txn");
    rd(0, 0, 8'd1, "frozen ch0 txn again");
    tick();
    n_cmp++; if (rd_valid !== 1'b0) begin n_bad++; $display("FAIL rd_valid drop: got %b want 0", rd_valid); end
    n_cmp++; if (rd_data !== 8'd1) begin n_bad++; $display("FAIL rd_data hold: got %0d want 1", rd_data); end
    while (exp_q.size() > 0) begin
      n_cmp++; e = exp_q.pop_front(); g = got_q.pop_front(); v = vld_q.pop_front(); nm = name_q.pop_front();
      if (v !== 1'b1 || g !== e) begin n_bad++; $display("FAIL %s: got valid=%b data=%0d want valid=1 data=%0d", nm, v, g, e); end
    end
  endtask

  task automatic test_reset_mid_run();
    logic [CNT_W-1:0] e, g; logic v; string nm;
    ap_start[0] = 1'b1;
    tick();
    ap_start[0] = 1'b0;
    tick(3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_cmp++; if (busy !== '0) begin n_bad++; $display("FAIL mid-run reset busy: got %b want 0", busy); end
    rd(0, 0, 8'd0, "mid reset txn");
    rd(0, 1, 8'd0, "mid reset busy_cyc");
    rd(0, 4, 8'd0, "mid reset last_lat");
    rd(0, 6, 8'd0, "mid reset status");
    ap_start[0] = 1'b1;
    tick();
    ap_start[0] = 1'b0;
    tick();
    ap_done[0] = 1'b1;
    tick();
    ap_done[0] = 1'b0;
    rd(0, 0, 8'd1, "post reset txn");
    rd(0, 4, 8'd3, "post reset last_lat");
    rd(0, 5, 8'd3, "post reset max_lat");
    while (exp_q.size() > 0) begin
      n_cmp++; e = exp_q.pop_front(); g = got_q.pop_front(); v = vld_q.pop_front(); nm = name_q.pop_front();
      if (v !== 1'b1 || g !== e) begin n_bad++; $display("FAIL %s: got valid=%b data=%0d want valid=1 data=%0d", nm, v, g, e); end
    end
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;
    test_reset();
    test_txn_ch0();
    test_done_wait();
    test_back_to_back();
    test_saturation();
    test_finish();
    test_reset_mid_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
